// File: rtl/rvc_fetch_aligner.sv
// Fetch aligner: word fetches into a 4-entry halfword queue, presents one
// RVC (zero-extended) or 32-bit instruction per cycle with its own PC.
module rvc_fetch_aligner #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_valid,
  input  logic [31:0] imem_data,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        is_compressed
);

  localparam int unsigned QDEPTH = 4;
  localparam int unsigned CNT_W  = 3;
  localparam int unsigned HW_W   = 16;

  logic [HW_W-1:0]  q      [QDEPTH];
  logic [HW_W-1:0]  q_next [QDEPTH];
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_mid;
  logic [CNT_W-1:0] cnt_next;
  logic [31:0]      head_pc;
  logic [31:0]      fetch_pc;
  logic             outstanding;
  logic             drop;
  logic             skip_low;

  logic [HW_W-1:0]  hw0;
  logic [HW_W-1:0]  hw1;
  logic             compressed;
  logic             avail;
  logic             pop;
  logic             resp;
  logic [1:0]       pop_n;
  logic [1:0]       push_n;
  logic [1:0]       wr_idx;

  // Presented instruction and fetch request, decoded from the queue head.
  always_comb begin
    hw0           = q[0];
    hw1           = q[1];
    compressed    = (hw0[1:0] != 2'b11);
    avail         = ((cnt >= 3'd1) && compressed) || ((cnt >= 3'd2) && !compressed);
    inst_valid    = !rst && avail;
    inst          = '0;
    pc            = '0;
    is_compressed = 1'b0;
    if (inst_valid) begin
      inst          = compressed ? {16'd0, hw0} : {hw1, hw0};
      pc            = head_pc;
      is_compressed = compressed;
    end
    imem_req  = !rst && !redirect && !outstanding && (cnt <= 3'd2);
    imem_addr = rst ? '0 : fetch_pc;
  end

  // Next queue contents: shift out popped halfwords, then append the response.
  always_comb begin
    pop    = inst_valid && inst_ready && !redirect;
    pop_n  = pop ? (compressed ? 2'd1 : 2'd2) : 2'd0;
    resp   = imem_valid && outstanding;
    push_n = (resp && !drop) ? (skip_low ? 2'd1 : 2'd2) : 2'd0;
    q_next = q;
    case (pop_n)
      2'd1: begin
        q_next[0] = q[1];
        q_next[1] = q[2];
        q_next[2] = q[3];
        q_next[3] = '0;
      end
      2'd2: begin
        q_next[0] = q[2];
        q_next[1] = q[3];
        q_next[2] = '0;
        q_next[3] = '0;
      end
      default: ;
    endcase
    cnt_mid = cnt - CNT_W'(pop_n);
    wr_idx  = cnt_mid[1:0];
    if (push_n == 2'd1) begin
      q_next[wr_idx] = imem_data[31:16];
    end else if (push_n == 2'd2) begin
      q_next[wr_idx]        = imem_data[15:0];
      q_next[wr_idx + 2'd1] = imem_data[31:16];
    end
    cnt_next = cnt_mid + CNT_W'(push_n);
  end

  // State update; redirect flushes and marks an in-flight response for discard.
  always_ff @(posedge clk) begin
    if (rst) begin
      q           <= '{default: '0};
      cnt         <= '0;
      head_pc     <= RESET_PC & ~32'd1;
      fetch_pc    <= RESET_PC & ~32'd3;
      skip_low    <= RESET_PC[1];
      outstanding <= 1'b0;
      drop        <= 1'b0;
    end else if (redirect) begin
      cnt      <= '0;
      head_pc  <= redirect_pc & ~32'd1;
      fetch_pc <= redirect_pc & ~32'd3;
      skip_low <= redirect_pc[1];
      if (outstanding && !imem_valid) begin
        drop <= 1'b1;
      end else begin
        drop        <= 1'b0;
        outstanding <= 1'b0;
      end
    end else begin
      q   <= q_next;
      cnt <= cnt_next;
      if (pop) begin
        head_pc <= head_pc + (compressed ? 32'd2 : 32'd4);
      end
      if (imem_req) begin
        outstanding <= 1'b1;
        fetch_pc    <= fetch_pc + 32'd4;
      end else if (resp) begin
        outstanding <= 1'b0;
        if (drop) begin
          drop <= 1'b0;
        end else if (skip_low) begin
          skip_low <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_rvc_fetch_aligner.sv
// Directed bench for rvc_fetch_aligner: memory model with configurable latency
// and an expected-instruction scoreboard; a second instance covers PC wrap.
module tb_rvc_fetch_aligner;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_valid;
  logic [31:0] imem_data;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] pc;
  logic        is_compressed;

  logic        rst_w;
  logic        imem_req_w;
  logic [31:0] imem_addr_w;
  logic        imem_valid_w;
  logic [31:0] imem_data_w;
  logic        redirect_w;
  logic [31:0] redirect_pc_w;
  logic        inst_valid_w;
  logic        inst_ready_w;
  logic [31:0] inst_w;
  logic [31:0] pc_w;
  logic        is_compressed_w;

  typedef struct packed {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        comp;
  } exp_t;

  typedef struct {
    logic [31:0] addr;
    int          due;
  } pend_t;

  exp_t        sb   [$];
  pend_t       pend [$];
  logic [31:0] mem  [logic [31:0]];
  int          lat    = 1;
  int          ncyc   = 0;
  int          checks = 0;
  int          errors = 0;

  rvc_fetch_aligner #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_valid(imem_valid), .imem_data(imem_data), .redirect(redirect),
    .redirect_pc(redirect_pc), .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst(inst), .pc(pc), .is_compressed(is_compressed)
  );

  rvc_fetch_aligner #(.RESET_PC(32'hFFFF_FFFC)) dut_w (
    .clk(clk), .rst(rst_w), .imem_req(imem_req_w), .imem_addr(imem_addr_w),
    .imem_valid(imem_valid_w), .imem_data(imem_data_w), .redirect(redirect_w),
    .redirect_pc(redirect_pc_w), .inst_valid(inst_valid_w), .inst_ready(inst_ready_w),
    .inst(inst_w), .pc(pc_w), .is_compressed(is_compressed_w)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0001_0001;
  endfunction

  // Memory: answers each accepted request lat cycles later, in order.
  initial begin
    pend_t p;
    imem_valid = 1'b0;
    imem_data  = '0;
    forever begin
      @(negedge clk);
      #1;
      imem_valid = 1'b0;
      imem_data  = '0;
      if (pend.size() > 0 && pend[0].due <= ncyc) begin
        p          = pend.pop_front();
        imem_valid = 1'b1;
        imem_data  = mem_rd(p.addr);
      end
      if (imem_req && !rst) pend.push_back('{addr: imem_addr, due: ncyc + lat});
      ncyc++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic exp_push(input logic [31:0] i, input logic [31:0] p, input logic c);
    sb.push_back('{inst: i, pc: p, comp: c});
  endtask

  // Accept n instructions, asserting ready only when one is valid.
  task automatic consume(input int n);
    int   got;
    int   budget;
    exp_t e;
    got    = 0;
    budget = 0;
    while (got < n && budget < 200) begin
      if (inst_valid) begin
        inst_ready = 1'b1;
        chk("sb_nonempty", 32'(sb.size() != 0), 32'd1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          chk("inst", inst, e.inst);
          chk("pc", pc, e.pc);
          chk("is_compressed", 32'(is_compressed), 32'(e.comp));
        end
        got++;
      end else begin
        inst_ready = 1'b0;
      end
      @(negedge clk);
      budget++;
    end
    inst_ready = 1'b0;
    chk("consume_count", 32'(got), 32'(n));
  endtask

  task automatic wait_req(input string tag, input logic [31:0] exp_addr);
    int b;
    b = 0;
    #1;
    while (!imem_req && b < 100) begin
      @(negedge clk);
      #1;
      b++;
    end
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    chk({tag, "_addr"}, imem_addr, exp_addr);
  endtask

  task automatic redirect_to(input logic [31:0] npc);
    redirect    = 1'b1;
    redirect_pc = npc;
    #1;
    chk("redirect_req_low", 32'(imem_req), 32'd0);
    @(negedge clk);
    redirect = 1'b0;
  endtask

  initial begin
    rst           = 1'b1;
    rst_w         = 1'b1;
    redirect      = 1'b0;
    redirect_pc   = '0;
    inst_ready    = 1'b0;
    imem_valid_w  = 1'b0;
    imem_data_w   = '0;
    redirect_w    = 1'b0;
    redirect_pc_w = '0;
    inst_ready_w  = 1'b0;

    mem[32'h0000_0000] = 32'h00A0_0093;
    mem[32'h0000_0004] = 32'h4501_0505;
    mem[32'h0000_0010] = 32'h9999_9999;
    mem[32'h0000_0020] = 32'h0093_0505;
    mem[32'h0000_0024] = 32'h0001_00A0;
    mem[32'h0000_0100] = 32'h1234_5678;
    mem[32'h0000_0200] = 32'h0005_0001;
    mem[32'h0000_0204] = 32'h000D_0009;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_imem_req", 32'(imem_req), 32'd0);
    chk("rst_imem_addr", imem_addr, 32'd0);
    chk("rst_inst_valid", 32'(inst_valid), 32'd0);
    chk("rst_inst", inst, 32'd0);
    chk("rst_pc", pc, 32'd0);
    chk("rst_is_compressed", 32'(is_compressed), 32'd0);
    chk("rst_w_imem_req", 32'(imem_req_w), 32'd0);
    chk("rst_w_inst_valid", 32'(inst_valid_w), 32'd0);

    // First fetch: 32-bit at 0, then two RVC from word 4
    rst = 1'b0;
    #1;
    chk("first_req", 32'(imem_req), 32'd1);
    chk("first_addr", imem_addr, 32'd0);
    @(negedge clk);
    chk("first_not_yet_valid", 32'(inst_valid), 32'd0);
    @(negedge clk);
    chk("first_valid", 32'(inst_valid), 32'd1);
    exp_push(32'h00A0_0093, 32'h0000_0000, 1'b0);
    exp_push(32'h0000_0505, 32'h0000_0004, 1'b1);
    exp_push(32'h0000_4501, 32'h0000_0006, 1'b1);
    consume(3);

    // Straddling 32-bit instruction with slow memory
    lat = 4;
    exp_push(32'h0000_0505, 32'h0000_0020, 1'b1);
    exp_push(32'h00A0_0093, 32'h0000_0022, 1'b0);
    exp_push(32'h0000_0001, 32'h0000_0026, 1'b1);
    redirect_to(32'h0000_0020);
    consume(1);
    chk("straddle_wait", 32'(inst_valid), 32'd0);
    consume(2);

    // Redirect while a fetch is in flight: stale word dropped, low half skipped
    @(negedge clk);
    redirect_to(32'h0000_0010);
    wait_req("fetch10", 32'h0000_0010);
    @(negedge clk);
    redirect_to(32'h0000_0102);
    wait_req("fetch100", 32'h0000_0100);
    @(negedge clk);
    exp_push(32'h0000_1234, 32'h0000_0102, 1'b1);
    consume(1);

    // Backpressure with a full queue
    lat = 1;
    redirect_to(32'h0000_0200);
    exp_push(32'h0000_0001, 32'h0000_0200, 1'b1);
    exp_push(32'h0000_0005, 32'h0000_0202, 1'b1);
    exp_push(32'h0000_0009, 32'h0000_0204, 1'b1);
    exp_push(32'h0000_000D, 32'h0000_0206, 1'b1);
    repeat (12) @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      chk("bp_valid", 32'(inst_valid), 32'd1);
      chk("bp_inst", inst, 32'h0000_0001);
      chk("bp_pc", pc, 32'h0000_0200);
      chk("bp_no_req", 32'(imem_req), 32'd0);
      @(negedge clk);
    end
    consume(4);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    // PC wrap on the second instance
    @(negedge clk);
    rst_w = 1'b0;
    #1;
    chk("wrap_req", 32'(imem_req_w), 32'd1);
    chk("wrap_addr", imem_addr_w, 32'hFFFF_FFFC);
    @(negedge clk);
    imem_valid_w = 1'b1;
    imem_data_w  = 32'h00A0_0093;
    @(negedge clk);
    imem_valid_w = 1'b0;
    chk("wrap_inst", inst_w, 32'h00A0_0093);
    chk("wrap_pc", pc_w, 32'hFFFF_FFFC);
    chk("wrap_is_compressed", 32'(is_compressed_w), 32'd0);
    chk("wrap_next_req", 32'(imem_req_w), 32'd1);
    chk("wrap_next_addr", imem_addr_w, 32'h0000_0000);
    inst_ready_w = 1'b1;
    @(negedge clk);
    inst_ready_w = 1'b0;
    imem_valid_w = 1'b1;
    imem_data_w  = 32'h0000_0001;
    chk("wrap_gap_valid", 32'(inst_valid_w), 32'd0);
    @(negedge clk);
    imem_valid_w = 1'b0;
    chk("wrap2_inst", inst_w, 32'h0000_0001);
    chk("wrap2_pc", pc_w, 32'h0000_0000);
    chk("wrap2_is_compressed", 32'(is_compressed_w), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
